rtc_lectura_timing: RTL and testbench

- Upstream timing generator for the RTC read path. It produces the 0..42 frame counter `cont_lectura`, which drives the read-sequence block that selects the address (F0, 20..26, 41..43) and pulses the register-bank enables at 27/33.
- It also generates the multiplexed Intel-style RTC bus strobes (cs_n, ad, wr_n, rd_n) and the address-bus drive enable.
- It counts 11 frames per read burst and reports completion to the main FSM.

---
 rtl/rtc_bus_pkg.sv | 56 +++++
 rtl/rtc_frame_counter.sv | 54 +++++
 rtl/rtc_lectura_timing.sv | 75 +++++++
 tb/tb_rtc_lectura_timing.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared timing constants for the RTC multiplexed-bus read path.
// Window bounds are in cont_lectura units and are inclusive at both ends.
package rtc_bus_pkg;

    localparam logic [5:0] ADDR_START    = 6'd8;
    localparam logic [5:0] WR_START      = 6'd9;
    localparam logic [5:0] WR_END        = 6'd14;
    localparam logic [5:0] DRV_END       = 6'd15;
    localparam logic [5:0] ADDR_END      = 6'd16;
    localparam logic [5:0] DATA_CS_START = 6'd20;
    localparam logic [5:0] RD_START      = 6'd21;
    localparam logic [5:0] RD_END        = 6'd34;
    localparam logic [5:0] DATA_CS_END   = 6'd35;
    localparam logic [5:0] FRAME_LAST    = 6'd42;

    // Register-bank capture window used by the downstream read-sequence block.
    localparam logic [5:0] CAPT_ON       = 6'd27;
    localparam logic [5:0] CAPT_OFF      = 6'd33;

    localparam int N_FRAMES_DEF = 11;

    typedef enum logic [2:0] {
        WIN_ADDR    = 3'd0,
        WIN_WR      = 3'd1,
        WIN_DRV     = 3'd2,
        WIN_DATA_CS = 3'd3,
        WIN_RD      = 3'd4
    } win_e;

    localparam int N_WIN = 5;

    typedef struct packed {
        logic [5:0] lo;
        logic [5:0] hi;
    } win_t;

    function automatic win_t win_bounds(input int idx);
        win_t w;
        w.lo = 6'd63;
        w.hi = 6'd0;
        case (idx)
            0:       begin w.lo = ADDR_START;    w.hi = ADDR_END;    end
            1:       begin w.lo = WR_START;      w.hi = WR_END;      end
            2:       begin w.lo = WR_START;      w.hi = DRV_END;     end
            3:       begin w.lo = DATA_CS_START; w.hi = DATA_CS_END; end
            4:       begin w.lo = RD_START;      w.hi = RD_END;      end
            default: begin w.lo = 6'd63;         w.hi = 6'd0;        end
        endcase
        return w;
    endfunction

    function automatic logic in_window(input logic [5:0] v, input win_t w);
        return (v >= w.lo) && (v <= w.hi);
    endfunction

endpackage

// File: rtl/rtc_frame_counter.sv
// Frame-position counter (0..FRAME_LAST) and frame index within a read burst.
// Exposes the next counter value so the strobes can be registered in step with it.
module rtc_frame_counter #(
    parameter int FRAME_LAST = 42,
    parameter int N_FRAMES   = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_leer,
    output logic [5:0] cont_lectura,
    output logic [5:0] cont_next,
    output logic       frame_done,
    output logic       lectura_done
);

    localparam int         IDX_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam logic [5:0] LAST_C   = 6'(FRAME_LAST);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FRAMES - 1);

    logic [5:0]       cont_reg;
    logic [IDX_W-1:0] frame_idx_reg;
    logic [IDX_W-1:0] frame_idx_next;

    always_comb begin
        cont_next      = '0;
        frame_idx_next = '0;
        if (enable_leer) begin
            if (cont_reg == LAST_C) begin
                cont_next      = '0;
                frame_idx_next = (frame_idx_reg == IDX_LAST) ? '0
                                                             : frame_idx_reg + 1'b1;
            end else begin
                cont_next      = cont_reg + 6'd1;
                frame_idx_next = frame_idx_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cont_reg      <= '0;
            frame_idx_reg <= '0;
        end else begin
            cont_reg      <= cont_next;
            frame_idx_reg <= frame_idx_next;
        end
    end

    // Pulses follow the live enable so an aborted frame never reports completion.
    assign frame_done   = enable_leer && (cont_reg == LAST_C);
    assign lectura_done = frame_done && (frame_idx_reg == IDX_LAST);
    assign cont_lectura = cont_reg;

endmodule

// File: rtl/rtc_lectura_timing.sv
// RTC read-path timing generator: frame counter plus registered Intel-style
// bus strobes (cs_n, ad, wr_n, rd_n) and the FPGA address-bus drive enable.
module rtc_lectura_timing #(
    parameter int FRAME_LAST = int'(rtc_bus_pkg::FRAME_LAST),
    parameter int N_FRAMES   = rtc_bus_pkg::N_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_leer,
    output logic [5:0] cont_lectura,
    output logic       cs_n,
    output logic       ad,
    output logic       wr_n,
    output logic       rd_n,
    output logic       bus_drive,
    output logic       frame_done,
    output logic       lectura_done
);

    import rtc_bus_pkg::*;

    logic [5:0]       cont_next;
    logic [N_WIN-1:0] win_hit;

    logic cs_n_reg;
    logic ad_reg;
    logic wr_n_reg;
    logic rd_n_reg;
    logic bus_drive_reg;

    rtc_frame_counter #(
        .FRAME_LAST (FRAME_LAST),
        .N_FRAMES   (N_FRAMES)
    ) u_frame_counter (
        .clk          (clk),
        .rst          (rst),
        .enable_leer  (enable_leer),
        .cont_lectura (cont_lectura),
        .cont_next    (cont_next),
        .frame_done   (frame_done),
        .lectura_done (lectura_done)
    );

    // Decoding the next count lets each registered strobe line up with the
    // cont_lectura value it belongs to. A disabled counter yields 0, which
    // lies outside every window, so strobes drop with the counter.
    generate
        for (genvar gi = 0; gi < N_WIN; gi++) begin : g_win
            assign win_hit[gi] = in_window(cont_next, win_bounds(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_n_reg      <= 1'b1;
            ad_reg        <= 1'b1;
            wr_n_reg      <= 1'b1;
            rd_n_reg      <= 1'b1;
            bus_drive_reg <= 1'b0;
        end else begin
            cs_n_reg      <= ~(win_hit[WIN_ADDR] | win_hit[WIN_DATA_CS]);
            ad_reg        <= ~win_hit[WIN_ADDR];
            wr_n_reg      <= ~win_hit[WIN_WR];
            rd_n_reg      <= ~win_hit[WIN_RD];
            bus_drive_reg <= win_hit[WIN_DRV];
        end
    end

    assign cs_n      = cs_n_reg;
    assign ad        = ad_reg;
    assign wr_n      = wr_n_reg;
    assign rd_n      = rd_n_reg;
    assign bus_drive = bus_drive_reg;

endmodule

// File: tb/tb_rtc_lectura_timing.sv
// Directed and randomised checks of the RTC read-path timing generator.
module tb_rtc_lectura_timing;

    logic       clk;
    logic       rst;
    logic       enable_leer;
    logic [5:0] cont_lectura;
    logic       cs_n;
    logic       ad;
    logic       wr_n;
    logic       rd_n;
    logic       bus_drive;
    logic       frame_done;
    logic       lectura_done;

    int errors;
    int checks;

    rtc_lectura_timing dut (
        .clk          (clk),
        .rst          (rst),
        .enable_leer  (enable_leer),
        .cont_lectura (cont_lectura),
        .cs_n         (cs_n),
        .ad           (ad),
        .wr_n         (wr_n),
        .rd_n         (rd_n),
        .bus_drive    (bus_drive),
        .frame_done   (frame_done),
        .lectura_done (lectura_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {cs_n, ad, wr_n, rd_n, bus_drive} at a given frame position.
    function automatic logic [4:0] exp_strobes(input int c);
        logic e_cs_n, e_ad, e_wr_n, e_rd_n, e_drv;
        e_ad   = !(c >= 8 && c <= 16);
        e_cs_n = !((c >= 8 && c <= 16) || (c >= 20 && c <= 35));
        e_wr_n = !(c >= 9 && c <= 14);
        e_rd_n = !(c >= 21 && c <= 34);
        e_drv  = (c >= 9 && c <= 15);
        return {e_cs_n, e_ad, e_wr_n, e_rd_n, e_drv};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        rst = 1'b0;
        enable_leer = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable_leer = 1'b1;
        repeat (3) step();
        checks++;
        if ({cs_n, ad, wr_n, rd_n, bus_drive} !== 5'b11110) begin
            errors++;
            $display("FAIL reset_strobes got=%b want=11110", {cs_n, ad, wr_n, rd_n, bus_drive});
        end
        checks++;
        if (cont_lectura !== 6'd0 || frame_done !== 1'b0 || lectura_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_counter got cont=%0d fd=%b ld=%b want 0/0/0",
                     cont_lectura, frame_done, lectura_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cont_lectura !== 6'(i)) begin
                errors++;
                $display("FAIL reset_release_cont got=%0d want=%0d", cont_lectura, i);
            end
            step();
        end
        $display("test_reset: done errors=%0d checks=%0d", errors, checks);
        go_idle();
    endtask

    task automatic test_single_frame();
        enable_leer = 1'b1;
        for (int c = 0; c <= 42; c++) begin
            checks++;
            if (cont_lectura !== 6'(c)) begin
                errors++;
                $display("FAIL frame_cont got=%0d want=%0d", cont_lectura, c);
            end
            checks++;
            if ({cs_n, ad, wr_n, rd_n, bus_drive} !== exp_strobes(c)) begin
                errors++;
                $display("FAIL frame_strobes cont=%0d got=%b want=%b",
                         c, {cs_n, ad, wr_n, rd_n, bus_drive}, exp_strobes(c));
            end
            checks++;
            if (frame_done !== (c == 42)) begin
                errors++;
                $display("FAIL frame_done cont=%0d got=%b want=%b", c, frame_done, (c == 42));
            end
            step();
        end
        checks++;
        if (cont_lectura !== 6'd0) begin
            errors++;
            $display("FAIL frame_wrap got=%0d want=0", cont_lectura);
        end
        $display("test_single_frame: done errors=%0d checks=%0d", errors, checks);
        go_idle();
    endtask

    task automatic test_full_burst();
        int n_fd, n_ld, ld_cycle;
        n_fd = 0;
        n_ld = 0;
        ld_cycle = -1;
        enable_leer = 1'b1;
        for (int t = 0; t < 473; t++) begin
            if (frame_done === 1'b1) n_fd++;
            if (lectura_done === 1'b1) begin
                n_ld++;
                ld_cycle = t;
            end
            step();
        end
        checks++;
        if (n_fd != 11) begin
            errors++;
            $display("FAIL burst_frame_done_count got=%0d want=11", n_fd);
        end
        checks++;
        if (n_ld != 1) begin
            errors++;
            $display("FAIL burst_lectura_done_count got=%0d want=1", n_ld);
        end
        checks++;
        if (ld_cycle != 472) begin
            errors++;
            $display("FAIL burst_lectura_done_cycle got=%0d want=472", ld_cycle);
        end
        checks++;
        if (cont_lectura !== 6'd0) begin
            errors++;
            $display("FAIL burst_cont_after got=%0d want=0", cont_lectura);
        end
        $display("test_full_burst: done errors=%0d checks=%0d", errors, checks);
        go_idle();
    endtask

    task automatic test_abort();
        int n_ld, ld_cycle;
        enable_leer = 1'b1;
        repeat (3 * 43 + 25) step();
        checks++;
        if (cont_lectura !== 6'd25 || rd_n !== 1'b0) begin
            errors++;
            $display("FAIL abort_pre got cont=%0d rd_n=%b want 25/0", cont_lectura, rd_n);
        end
        enable_leer = 1'b0;
        step();
        checks++;
        if (cont_lectura !== 6'd0 || rd_n !== 1'b1 || cs_n !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_post got cont=%0d rd_n=%b cs_n=%b fd=%b want 0/1/1/0",
                     cont_lectura, rd_n, cs_n, frame_done);
        end
        n_ld = 0;
        ld_cycle = -1;
        enable_leer = 1'b1;
        for (int t = 0; t < 473; t++) begin
            if (lectura_done === 1'b1) begin
                n_ld++;
                ld_cycle = t;
            end
            step();
        end
        checks++;
        if (n_ld != 1 || ld_cycle != 472) begin
            errors++;
            $display("FAIL abort_restart got count=%0d cycle=%0d want 1/472", n_ld, ld_cycle);
        end
        $display("test_abort: done errors=%0d checks=%0d", errors, checks);
        go_idle();
    endtask

    task automatic test_mid_reset();
        enable_leer = 1'b1;
        repeat (12) step();
        checks++;
        if (cont_lectura !== 6'd12 || wr_n !== 1'b0 || bus_drive !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got cont=%0d wr_n=%b drv=%b want 12/0/1",
                     cont_lectura, wr_n, bus_drive);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({cs_n, ad, wr_n, rd_n, bus_drive} !== 5'b11110 || cont_lectura !== 6'd0) begin
            errors++;
            $display("FAIL midrst_post got strobes=%b cont=%0d want 11110/0",
                     {cs_n, ad, wr_n, rd_n, bus_drive}, cont_lectura);
        end
        $display("test_mid_reset: done errors=%0d checks=%0d", errors, checks);
        go_idle();
    endtask

    task automatic test_invariant_sweep();
        int exp_cont, exp_idx;
        logic r, e, exp_fd, exp_ld;
        exp_cont = 0;
        exp_idx = 0;
        for (int t = 0; t < 10000; t++) begin
            r = ($urandom_range(0, 999) == 0);
            e = ($urandom_range(0, 399) != 0);
            rst = r;
            enable_leer = e;
            exp_fd = e && (exp_cont == 42);
            exp_ld = exp_fd && (exp_idx == 10);
            checks++;
            if (!(rd_n === 1'b0 && wr_n === 1'b0) && !(bus_drive === 1'b1 && rd_n !== 1'b1) &&
                !(rd_n === 1'b0 && (ad !== 1'b1 || cs_n !== 1'b0)) && cont_lectura <= 6'd42) begin
            end else begin
                errors++;
                $display("FAIL sweep_invariant t=%0d cont=%0d cs_n=%b ad=%b wr_n=%b rd_n=%b drv=%b",
                         t, cont_lectura, cs_n, ad, wr_n, rd_n, bus_drive);
            end
            checks++;
            if (cont_lectura !== 6'(exp_cont) ||
                {cs_n, ad, wr_n, rd_n, bus_drive} !== exp_strobes(exp_cont)) begin
                errors++;
                $display("FAIL sweep_state t=%0d got cont=%0d strobes=%b want %0d/%b",
                         t, cont_lectura, {cs_n, ad, wr_n, rd_n, bus_drive},
                         exp_cont, exp_strobes(exp_cont));
            end
            checks++;
            if (frame_done !== exp_fd || lectura_done !== exp_ld) begin
                errors++;
                $display("FAIL sweep_pulses t=%0d got fd=%b ld=%b want %b/%b",
                         t, frame_done, lectura_done, exp_fd, exp_ld);
            end
            if (r || !e) begin
                exp_cont = 0;
                exp_idx = 0;
            end else if (exp_cont == 42) begin
                exp_cont = 0;
                exp_idx = (exp_idx == 10) ? 0 : exp_idx + 1;
            end else begin
                exp_cont = exp_cont + 1;
            end
            step();
        end
        $display("test_invariant_sweep: done errors=%0d checks=%0d", errors, checks);
        go_idle();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        enable_leer = 1'b0;
        test_reset();
        test_single_frame();
        test_full_burst();
        test_abort();
        test_mid_reset();
        test_invariant_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
